// File: rtl/matmul_apb_pkg.sv
// Shared types and default widths for the matmul APB master engine.
// Holds the FSM state encoding and the default command record.
package matmul_apb_pkg;

  localparam int APB_DATA_W  = 16;
  localparam int APB_BUS_W   = 32;
  localparam int APB_ADDR_W  = 16;
  localparam int APB_STRB_W  = APB_BUS_W / 8;
  localparam int APB_DEPTH   = 4;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_BUS_W-1:0]  wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/matmul_apb_cmd_fifo.sv
// Command queue for the APB master: DEPTH entries of a packed command type.
// Registered read side only, so a pushed entry is visible the following cycle.
module matmul_apb_cmd_fifo
  import matmul_apb_pkg::*;
#(
  parameter int  DEPTH = APB_DEPTH,
  parameter type T     = apb_cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  T              mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == {(PW+1){1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // storage array; contents are don't-care until pointed at by a valid count
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/matmul_apb_master.sv
// APB master engine: queues write/read commands, runs SETUP/ACCESS with a
// wait-state timeout and returns one response per command.
module matmul_apb_master
  import matmul_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int BUS_WIDTH      = APB_BUS_W,
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int STRB_WIDTH     = BUS_WIDTH / 8,
  parameter int CMD_DEPTH      = APB_DEPTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [BUS_WIDTH-1:0]  pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic [BUS_WIDTH-1:0]  prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  if ((BUS_WIDTH % 8) != 0 || STRB_WIDTH != BUS_WIDTH / 8 || DATA_WIDTH > BUS_WIDTH ||
      TIMEOUT_CYCLES < 2 || CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_param_check
    $error("matmul_apb_master: illegal parameter set");
  end

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [STRB_WIDTH-1:0] strb;
  } cmd_t;

  apb_state_e               state_r, state_nx_s;
  logic [CNT_W-1:0]         wait_cnt_r;
  logic                     pop_s, cap_s, tmo_s;
  logic                     full_s, empty_s;
  logic [$clog2(CMD_DEPTH):0] count_s;
  cmd_t                     cmd_in_s, fifo_out_s;

  logic                     psel_r, penable_r, pwrite_r;
  logic [ADDR_WIDTH-1:0]    paddr_r;
  logic [BUS_WIDTH-1:0]     pwdata_r;
  logic [STRB_WIDTH-1:0]    pstrb_r;
  logic                     rsp_valid_r, rsp_err_r, rsp_timeout_r;
  logic [BUS_WIDTH-1:0]     rsp_rdata_r;

  // reads never carry byte strobes onto the bus
  assign cmd_in_s = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                      strb: cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}}};

  matmul_apb_cmd_fifo #(.DEPTH(CMD_DEPTH), .T(cmd_t)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (cmd_in_s),
    .pop   (pop_s),
    .dout  (fifo_out_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign cmd_ready   = ~full_s;
  assign busy        = (state_r != IDLE) || (count_s != '0);
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = pwrite_r;
  assign paddr       = paddr_r;
  assign pwdata      = pwdata_r;
  assign pstrb       = pstrb_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

  // next-state decode, FIFO pop and ACCESS completion strobes
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    cap_s      = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s      = 1'b1;
          state_nx_s = SETUP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SETUP: state_nx_s = ACCESS;
      ACCESS: begin
        if (pready) begin
          cap_s      = 1'b1;
          state_nx_s = RESP;
        end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_s      = 1'b1;
          state_nx_s = RESP;
        end else begin
          state_nx_s = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready && !empty_s) begin
          pop_s      = 1'b1;
          state_nx_s = SETUP;
        end else if (rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // state register and ACCESS wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      wait_cnt_r <= (state_r == ACCESS) ? wait_cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
    end
  end

  // APB outputs double as the holding registers for the popped command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= {ADDR_WIDTH{1'b0}};
      pwdata_r  <= {BUS_WIDTH{1'b0}};
      pstrb_r   <= {STRB_WIDTH{1'b0}};
    end else if (pop_s) begin
      psel_r    <= 1'b1;
      penable_r <= 1'b0;
      pwrite_r  <= fifo_out_s.write;
      paddr_r   <= fifo_out_s.addr;
      pwdata_r  <= fifo_out_s.wdata;
      pstrb_r   <= fifo_out_s.strb;
    end else if (state_r == SETUP) begin
      penable_r <= 1'b1;
    end else if (cap_s || tmo_s) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= {ADDR_WIDTH{1'b0}};
      pwdata_r  <= {BUS_WIDTH{1'b0}};
      pstrb_r   <= {STRB_WIDTH{1'b0}};
    end
  end

  // response capture; fields stay put until the next transfer completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= {BUS_WIDTH{1'b0}};
    end else if (cap_s || tmo_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_err_r     <= tmo_s ? 1'b1 : pslverr;
      rsp_timeout_r <= tmo_s;
      rsp_rdata_r   <= (cap_s && !pwrite_r) ? prdata : {BUS_WIDTH{1'b0}};
    end else if (state_r == RESP && rsp_ready) begin
      rsp_valid_r   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_apb_master.sv
// Directed bench for matmul_apb_master with a small APB slave model
// (programmable wait states, error injection, address-derived read data).
module tb_matmul_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_strb = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int total = 0;
  int bad   = 0;
  int wait_states = 0;
  logic slave_err = 1'b0;
  int acc_cnt;

  always #5 clk = ~clk;

  matmul_apb_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  // slave model: ready after wait_states ACCESS cycles
  always @(posedge clk or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else if (penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready  = penable && (acc_cnt >= wait_states);
  assign pslverr = pready && slave_err;
  assign prdata  = (paddr == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, paddr};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // push one command, then watch the bus until a response or 40 cycles
  task automatic do_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int pen_cycles, output logic got,
                        output logic [3:0] setup_strb, output logic idle_dirty);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    pen_cycles = 0; got = 1'b0; setup_strb = 4'hx; idle_dirty = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (penable) pen_cycles++;
      if (psel && !penable) setup_strb = pstrb;
      if (!psel && (pwrite || paddr != 16'h0 || pwdata != 32'h0 || pstrb != 4'h0)) idle_dirty = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int pen, k, last_t;
  logic got, dirty;
  logic [3:0] sstrb;

  initial begin
    // reset state
    @(negedge clk);
    check_eq("rst_psel", {31'h0, psel}, 32'h0);
    check_eq("rst_penable", {31'h0, penable}, 32'h0);
    check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_paddr", {16'h0, paddr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // write, zero wait: psel at N, penable N+1, rsp_valid N+2
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0004; cmd_wdata = 32'h12345678; cmd_strb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("w_idle_psel", {31'h0, psel}, 32'h0);
    check_eq("w_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check_eq("w_setup_sel_en", {30'h0, psel, penable}, 32'h2);
    check_eq("w_setup_addr", {16'h0, paddr}, 32'h0004);
    check_eq("w_setup_wdata", pwdata, 32'h12345678);
    check_eq("w_setup_ctl", {27'h0, pwrite, pstrb}, 32'h1F);
    @(negedge clk);
    check_eq("w_access_sel_en", {30'h0, psel, penable}, 32'h3);
    @(negedge clk);
    check_eq("w_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("w_rsp_err_tmo", {30'h0, rsp_err, rsp_timeout}, 32'h0);
    check_eq("w_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("w_rsp_bus_idle", {15'h0, psel, paddr}, 32'h0);
    ack_rsp();
    check_eq("w_after_ack", {30'h0, rsp_valid, busy}, 32'h0);

    // read with 3 wait states; strobes must be dropped on reads
    wait_states = 3;
    do_cmd(1'b0, 16'h0010, 32'h0, 4'hF, pen, got, sstrb, dirty);
    check_eq("r_got", {31'h0, got}, 32'h1);
    check_eq("r_penable_cycles", pen, 32'd4);
    check_eq("r_rdata", rsp_rdata, 32'hDEADBEEF);
    check_eq("r_err", {30'h0, rsp_err, rsp_timeout}, 32'h0);
    check_eq("r_strb_zero", {28'h0, sstrb}, 32'h0);
    check_eq("r_idle_bus_clean", {31'h0, dirty}, 32'h0);
    ack_rsp();

    // pready stuck low: abort after 16 ACCESS cycles
    wait_states = 1000;
    do_cmd(1'b0, 16'h0020, 32'h0, 4'h0, pen, got, sstrb, dirty);
    check_eq("t_got", {31'h0, got}, 32'h1);
    check_eq("t_penable_cycles", pen, 32'd16);
    check_eq("t_err_tmo", {30'h0, rsp_err, rsp_timeout}, 32'h3);
    check_eq("t_psel_dropped", {31'h0, psel}, 32'h0);
    check_eq("t_rdata", rsp_rdata, 32'h0);
    ack_rsp();

    // slave error on a write
    wait_states = 0; slave_err = 1'b1;
    do_cmd(1'b1, 16'h0008, 32'hCAFEF00D, 4'h3, pen, got, sstrb, dirty);
    check_eq("e_got", {31'h0, got}, 32'h1);
    check_eq("e_err_tmo", {30'h0, rsp_err, rsp_timeout}, 32'h2);
    check_eq("e_strb", {28'h0, sstrb}, 32'h3);
    ack_rsp();
    slave_err = 1'b0;

    // back-pressure: one in RESP, four queued, sixth refused
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("bp_ready_%0d", i), {31'h0, cmd_ready}, (i < 5) ? 32'h1 : 32'h0);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = (i < 5) ? 16'h0100 + 16'(i) : 16'h01FF;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check_eq("bp_held_valid", {31'h0, rsp_valid}, 32'h1);
    check_eq("bp_held_rdata", rsp_rdata, 32'hA5A50100);
    rsp_ready = 1'b1;
    k = 0; last_t = 0;
    for (int c = 0; c < 60; c++) begin
      if (rsp_valid) begin
        check_eq($sformatf("bp_rsp_%0d", k), rsp_rdata, {16'hA5A5, 16'h0100 + 16'(k)});
        if (k > 0) check_eq($sformatf("bp_gap_%0d", k), c - last_t, 32'd3);
        last_t = c;
        k++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check_eq("bp_rsp_count", k, 32'd5);
    check_eq("bp_idle", {31'h0, busy}, 32'h0);

    // async reset in the middle of ACCESS with another command queued
    wait_states = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
    @(negedge clk);
    cmd_addr = 16'h0034;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (penable) got = 1'b1;
    end
    check_eq("ar_reached_access", {31'h0, got}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("ar_sel_en", {30'h0, psel, penable}, 32'h0);
    check_eq("ar_busy", {31'h0, busy}, 32'h0);
    check_eq("ar_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_states = 0;
    dirty = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid || psel) dirty = 1'b1;
    end
    check_eq("ar_no_activity", {31'h0, dirty}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
